// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, with sign fix-up and a single register-file write-back on completion.
module div_unit #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [1:0]                op_i,
  input  logic [CPU_WIDTH-1:0]      dividend_i,
  input  logic [CPU_WIDTH-1:0]      divisor_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                      flush_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      wr_en_o,
  output logic [REG_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [CPU_WIDTH-1:0]      wr_data_o
);

  localparam int CNT_W = $clog2(CPU_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPU_WIDTH - 1);
  localparam logic [CPU_WIDTH-1:0] MOST_NEG = {1'b1, {(CPU_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                      state_q;
  logic                        is_rem_q;
  logic                        quo_neg_q;
  logic                        dvd_neg_q;
  logic [REG_ADDR_WIDTH-1:0]   rd_q;
  logic [CPU_WIDTH-1:0]        dvs_q;
  logic [CPU_WIDTH-1:0]        rem_q;
  logic [CPU_WIDTH-1:0]        quo_q;
  logic [CNT_W-1:0]            count_q;

  logic                        is_signed;
  logic [CPU_WIDTH-1:0]        dvd_abs;
  logic [CPU_WIDTH-1:0]        dvs_abs;
  logic                        div_zero;
  logic                        overflow;
  logic [CPU_WIDTH-1:0]        special_result;

  logic [CPU_WIDTH:0]          shifted;
  logic [CPU_WIDTH:0]          diff;
  logic [CPU_WIDTH-1:0]        rem_next;
  logic [CPU_WIDTH-1:0]        quo_next;
  logic [CPU_WIDTH-1:0]        quo_final;
  logic [CPU_WIDTH-1:0]        rem_final;
  logic [CPU_WIDTH-1:0]        calc_result;

  // Launch-time decode: operand magnitudes and the two architecturally fixed
  // special cases. The overflow quotient equals the dividend (most negative).
  always_comb begin
    is_signed = ~op_i[0];
    dvd_abs   = (is_signed && dividend_i[CPU_WIDTH-1]) ? -dividend_i : dividend_i;
    dvs_abs   = (is_signed && divisor_i[CPU_WIDTH-1])  ? -divisor_i  : divisor_i;
    div_zero  = (divisor_i == '0);
    overflow  = is_signed && (dividend_i == MOST_NEG) && (divisor_i == '1);
    if (div_zero)
      special_result = op_i[1] ? dividend_i : '1;
    else
      special_result = op_i[1] ? '0 : dividend_i;
  end

  // One restoring step: shift {rem,quo}, trial-subtract with a spare bit so the
  // borrow shows up as the top bit, then fold in the sign fix-up for the last step.
  always_comb begin
    shifted = {rem_q, quo_q[CPU_WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[CPU_WIDTH]) begin
      rem_next = diff[CPU_WIDTH-1:0];
      quo_next = {quo_q[CPU_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[CPU_WIDTH-1:0];
      quo_next = {quo_q[CPU_WIDTH-2:0], 1'b0};
    end
    quo_final   = quo_neg_q ? -quo_next : quo_next;
    rem_final   = dvd_neg_q ? -rem_next : rem_next;
    calc_result = is_rem_q ? rem_final : quo_final;
  end

  // Control FSM with registered outputs; flush overrides everything, and the
  // write-back bus only changes on entry to DONE so it holds between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      is_rem_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      dvd_neg_q <= 1'b0;
      rd_q      <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      count_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      wr_en_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o  <= 1'b0;
          wr_en_o <= 1'b0;
          if (start_i) begin
            busy_o    <= 1'b1;
            is_rem_q  <= op_i[1];
            rd_q      <= rd_addr_i;
            quo_neg_q <= is_signed & (dividend_i[CPU_WIDTH-1] ^ divisor_i[CPU_WIDTH-1]);
            dvd_neg_q <= is_signed & dividend_i[CPU_WIDTH-1];
            dvs_q     <= dvs_abs;
            rem_q     <= '0;
            quo_q     <= dvd_abs;
            count_q   <= '0;
            if (div_zero || overflow) begin
              state_q   <= DONE;
              done_o    <= 1'b1;
              wr_en_o   <= (rd_addr_i != '0);
              wr_addr_o <= rd_addr_i;
              wr_data_o <= special_result;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= rem_next;
          quo_q   <= quo_next;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_CNT) begin
            state_q   <= DONE;
            done_o    <= 1'b1;
            wr_en_o   <= (rd_q != '0);
            wr_addr_o <= rd_q;
            wr_data_o <= calc_result;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          wr_en_o <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          wr_en_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle RV32M divide/remainder unit.
- Sits between the register file read ports and its write port.
- Takes the rs1/rs2 operand values read from the register file, runs a radix-2 restoring division, and issues one write-back (enable, address, data) to the register file write port on completion.
- The pipeline stalls on busy_o.

Parameters:
- CPU_WIDTH, 32, operand/result width (iteration count equals CPU_WIDTH).
- REG_ADDR_WIDTH, 5, destination register address width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  launch request; sampled only in IDLE
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend_i  input  CPU_WIDTH  rs1 value
- divisor_i  input  CPU_WIDTH  rs2 value
- rd_addr_i  input  REG_ADDR_WIDTH  destination register
- flush_i  input  1  synchronous abort, no write-back
- busy_o  output  1  high in CALC and DONE
- done_o  output  1  one-cycle completion pulse
- wr_en_o  output  1  register file write enable
- wr_addr_o  output  REG_ADDR_WIDTH  register file write address
- wr_data_o  output  CPU_WIDTH  quotient or remainder

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. On reset:
  - state=IDLE; busy_o=0, done_o=0, wr_en_o=0.
  - wr_addr_o=0, wr_data_o=0; counter and datapath registers cleared.
- States: IDLE, CALC, DONE.
- IDLE, start_i=1 at edge E0:
  - Latch op, rd_addr, operand signs and absolute operand magnitudes.
  - Signed ops (DIV, REM) use the absolute value; unsigned ops (DIVU, REMU) use the raw value.
  - Normal case: go to CALC with count=0.
  - Special case (divisor==0, or signed op with dividend=0x80000000 and divisor=0xFFFFFFFF): go directly to DONE with the fixed result below.
- CALC, one iteration per edge:
  - Shift {rem,quo} left by 1.
  - Trial-subtract the divisor magnitude, using a (CPU_WIDTH+1)-bit subtract.
  - If the result is non-negative, keep it and set quo LSB to 1.
  - count++.
  - On the edge where count==CPU_WIDTH-1, apply sign fix-up and register the final result, then go to DONE.
- Sign fix-up (signed ops only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Results wrap modulo 2^CPU_WIDTH.
- DONE, exactly one cycle:
  - done_o=1.
  - wr_en_o=1 unless the latched rd_addr==0; rd_addr 0 gives no write but done_o still pulses.
  - wr_data_o = quotient for DIV/DIVU, remainder for REM/REMU.
  - Next edge: IDLE.
- Latency (start sampled at E0):
  - Normal: wr_en_o high between E32 and E33 (32 cycles); busy_o high for E0..E33.
  - Special cases: wr_en_o high between E0 and E1.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU); remainder = the original dividend.
  - Signed overflow: quotient 0x80000000, remainder 0.
- Back-to-back issue: start_i while busy_o=1 is ignored. A new start is accepted only in IDLE, so earliest re-issue is the edge after DONE.
- flush_i:
  - Highest priority, in any state: next state IDLE, no wr_en_o/done_o pulse.
  - If asserted in IDLE together with start_i, the start is dropped.
  - A flush sampled during DONE does not cancel the write already presented in that cycle.
- wr_addr_o/wr_data_o hold their last values outside DONE. Consumers qualify them with wr_en_o only.
- Operand inputs need only be valid in the start cycle; later changes have no effect.
- Reset mid-operation: immediate return to the reset values above; no write is issued.

Test Plan:
- DIVU 100/7, rd=5 → after 32 cycles: one-cycle wr_en_o, wr_addr_o=5, wr_data_o=14; REMU same operands → 2.
- DIV -7/2 (0xFFFFFFF9, 2) → 0xFFFFFFFD (-3); REM → 0xFFFFFFFF (-1); REM 7/-2 → 1.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF, REM 0x12345678/0 → 0x12345678; each written in the cycle after start (latency 1).
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0, latency 1.
- rd_addr=0 DIV 9/3 → done_o pulses, wr_en_o stays 0. start_i pulsed at cycle 10 of a running op → ignored: exactly one write.
- flush_i at cycle 15 of CALC → busy_o falls next edge, no write. rst_n low at cycle 20 → all outputs 0 immediately. A following start then completes normally.
